// File: rtl/mem_loader.sv
// Framed byte-stream boot loader: parses LEN(16, LE) | N x 32-bit LE words | CSUM
// and issues single-cycle word writes into a 2**ADDR_W x 32 program RAM port.
module mem_loader #(
    parameter int          ADDR_W    = 11,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                accept_s;
    logic                active_next_s;
    logic [15:0]         len_full_s;
    logic                len_too_big_s;
    logic                last_word_s;
    logic [7:0]          len_lo_r;
    logic [15:0]         len_r;
    logic [1:0]          lane_r;
    logic [ADDR_W-1:0]   index_r;
    logic [23:0]         word_r;
    logic [7:0]          csum_r;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        csum_add = acc + data;
    endfunction

    assign accept_s      = din_valid & din_ready;
    assign len_full_s    = {din, len_lo_r};
    assign len_too_big_s = ({1'b0, len_full_s} > MAX_WORDS);
    assign last_word_s   = ((17'(index_r) + 17'd1) == {1'b0, len_r});

    // Next-state decode; ready/busy are registered from the state being entered.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_LEN_LO;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    next_state_s = S_LEN_HI;
                end else begin
                    next_state_s = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (!accept_s) begin
                    next_state_s = S_LEN_HI;
                end else if (len_too_big_s) begin
                    next_state_s = S_FIN;
                end else if (len_full_s == 16'd0) begin
                    next_state_s = S_CSUM;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_DATA: begin
                if (accept_s && (lane_r == 2'd3) && last_word_s) begin
                    next_state_s = S_CSUM;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept_s) begin
                    next_state_s = S_FIN;
                end else begin
                    next_state_s = S_CSUM;
                end
            end
            S_FIN:   next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Handshake-visible activity flag for the state being entered.
    always_comb begin
        active_next_s = 1'b0;
        case (next_state_s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: active_next_s = 1'b1;
            default:                            active_next_s = 1'b0;
        endcase
    end

    // State register with registered ready/busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            din_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            din_ready <= active_next_s;
            busy      <= active_next_s;
        end
    end

    // Frame datapath: length capture, word assembly, write strobe and checksum verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= BASE;
            mem_din  <= 32'd0;
            done     <= 1'b0;
            error    <= 1'b0;
            len_lo_r <= 8'd0;
            len_r    <= 16'd0;
            lane_r   <= 2'd0;
            index_r  <= '0;
            word_r   <= 24'd0;
            csum_r   <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        csum_r   <= 8'd0;
                        index_r  <= '0;
                        lane_r   <= 2'd0;
                        len_lo_r <= 8'd0;
                        len_r    <= 16'd0;
                        word_r   <= 24'd0;
                    end
                end
                S_LEN_LO: begin
                    if (accept_s) begin
                        len_lo_r <= din;
                    end
                end
                S_LEN_HI: begin
                    if (accept_s) begin
                        len_r <= len_full_s;
                        if (len_too_big_s) begin
                            error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        csum_r <= csum_add(csum_r, din);
                        lane_r <= lane_r + 2'd1;
                        case (lane_r)
                            2'd0: word_r[7:0]   <= din;
                            2'd1: word_r[15:8]  <= din;
                            2'd2: word_r[23:16] <= din;
                            default: begin
                                // Lane 3 completes the word; the write fires next cycle.
                                mem_we   <= 1'b1;
                                mem_din  <= {din, word_r};
                                mem_addr <= BASE + index_r;
                                index_r  <= index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (accept_s) begin
                        if (din == csum_r) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
